// File: rtl/sqrt_fp_controller.sv
// Sequencer for a lampFP square root: classifies the operand, drives an external significand
// sqrt core, then normalises and rounds its Q2.14 result back into a packed lampFP value.
module sqrt_fp_controller #(
    parameter int unsigned E_DW    = 8,
    parameter int unsigned F_DW    = 7,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 doSqrt_i,
    input  logic [E_DW+F_DW:0]   op_i,
    output logic                 core_start_o,
    output logic [F_DW:0]        core_s_o,
    output logic                 core_exp_odd_o,
    input  logic                 core_valid_i,
    input  logic [15:0]          core_res_i,
    output logic                 valid_o,
    output logic [E_DW+F_DW:0]   res_o,
    output logic                 invalid_o,
    output logic                 err_o,
    output logic                 busy_o
);

    localparam int unsigned OP_W  = 1 + E_DW + F_DW;
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [E_DW-1:0]  EXP_ONES  = {E_DW{1'b1}};
    localparam logic [E_DW-1:0]  EXP_ONE   = 1;
    localparam logic [E_DW-1:0]  HALF_BIAS = (1 << (E_DW - 2)) - 1;
    localparam logic [F_DW-1:0]  FRAC_ZERO = '0;
    localparam logic [F_DW:0]    FRAC_ONE  = 1;
    localparam logic [OP_W-1:0]  QNAN      = {1'b0, EXP_ONES, 1'b1, {(F_DW-1){1'b0}}};
    localparam logic [OP_W-1:0]  PINF      = {1'b0, EXP_ONES, FRAC_ZERO};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StPost} state_t;

    state_t            r_state, w_state_nxt;
    logic [E_DW-1:0]   r_exp, w_exp_nxt;
    logic [F_DW:0]     r_core_s, w_core_s_nxt;
    logic              r_exp_odd, w_exp_odd_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [15:0]       r_core_res, w_core_res_nxt;
    logic              r_valid, w_valid_nxt;
    logic [OP_W-1:0]   r_res, w_res_nxt;
    logic              r_invalid, w_invalid_nxt;
    logic              r_err, w_err_nxt;

    logic              w_op_sign;
    logic [E_DW-1:0]   w_op_exp;
    logic [F_DW-1:0]   w_op_frac;
    logic              w_special;
    logic [OP_W-1:0]   w_spec_res;
    logic              w_spec_inv;

    logic [E_DW-1:0]   w_exp_base;
    logic [E_DW-1:0]   w_exp_norm;
    logic [13:0]       w_mant;
    logic [F_DW-1:0]   w_frac;
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [F_DW:0]     w_frac_rnd;
    logic [E_DW-1:0]   w_exp_fin;
    logic [OP_W-1:0]   w_post_res;

    assign w_op_sign = op_i[OP_W-1];
    assign w_op_exp  = op_i[OP_W-2:F_DW];
    assign w_op_frac = op_i[F_DW-1:0];

    // Operand classification; denormals flush to a signed zero before the sign test.
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = '0;
        w_spec_inv = 1'b0;
        if (w_op_exp == EXP_ONES && w_op_frac != FRAC_ZERO) begin
            w_spec_res = QNAN;
        end else if (w_op_exp == EXP_ONES) begin
            w_spec_res = w_op_sign ? QNAN : PINF;
            w_spec_inv = w_op_sign;
        end else if (w_op_exp == '0) begin
            w_spec_res = {w_op_sign, {(OP_W-1){1'b0}}};
        end else if (w_op_sign) begin
            w_spec_res = QNAN;
            w_spec_inv = 1'b1;
        end else begin
            w_special  = 1'b0;
        end
    end

    // (E + bias) >> 1 rewritten as (E >> 1) + bias/2 + E[0] to stay within E_DW bits.
    assign w_exp_base = {1'b0, r_exp[E_DW-1:1]} + HALF_BIAS + {{(E_DW-1){1'b0}}, r_exp[0]};

    always_comb begin
        w_mant     = r_core_res[13:0];
        w_exp_norm = w_exp_base;
        if (r_core_res[15]) begin
            w_mant     = r_core_res[14:1];
            w_exp_norm = w_exp_base + EXP_ONE;
        end else if (!r_core_res[14]) begin
            w_mant     = {r_core_res[12:0], 1'b0};
            w_exp_norm = w_exp_base - EXP_ONE;
        end
    end

    assign w_frac     = w_mant[13 -: F_DW];
    assign w_guard    = w_mant[13 - F_DW];
    assign w_sticky   = |w_mant[12 - F_DW:0];
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + (w_round_up ? FRAC_ONE : '0);
    assign w_exp_fin  = w_frac_rnd[F_DW] ? (w_exp_norm + EXP_ONE) : w_exp_norm;
    assign w_post_res = {1'b0, w_exp_fin, w_frac_rnd[F_DW-1:0]};

    always_comb begin
        w_state_nxt    = r_state;
        w_exp_nxt      = r_exp;
        w_core_s_nxt   = r_core_s;
        w_exp_odd_nxt  = r_exp_odd;
        w_cnt_nxt      = r_cnt;
        w_core_res_nxt = r_core_res;
        w_valid_nxt    = 1'b0;
        w_res_nxt      = '0;
        w_invalid_nxt  = 1'b0;
        w_err_nxt      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (doSqrt_i) begin
                    w_exp_nxt     = w_op_exp;
                    w_core_s_nxt  = {1'b1, w_op_frac};
                    w_exp_odd_nxt = ~w_op_exp[0];
                    if (w_special) begin
                        w_valid_nxt   = 1'b1;
                        w_res_nxt     = w_spec_res;
                        w_invalid_nxt = w_spec_inv;
                    end else begin
                        w_state_nxt   = StIssue;
                    end
                end
            end
            StIssue: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StWait;
            end
            StWait: begin
                if (core_valid_i) begin
                    w_core_res_nxt = core_res_i;
                    w_state_nxt    = StPost;
                end else if (r_cnt == CNT_LAST) begin
                    w_valid_nxt = 1'b1;
                    w_res_nxt   = QNAN;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            StPost: begin
                w_valid_nxt = 1'b1;
                w_res_nxt   = w_post_res;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_exp      <= '0;
            r_core_s   <= '0;
            r_exp_odd  <= 1'b0;
            r_cnt      <= '0;
            r_core_res <= '0;
            r_valid    <= 1'b0;
            r_res      <= '0;
            r_invalid  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_exp      <= w_exp_nxt;
            r_core_s   <= w_core_s_nxt;
            r_exp_odd  <= w_exp_odd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_core_res <= w_core_res_nxt;
            r_valid    <= w_valid_nxt;
            r_res      <= w_res_nxt;
            r_invalid  <= w_invalid_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign core_start_o   = (r_state == StIssue);
    assign core_s_o       = r_core_s;
    assign core_exp_odd_o = r_exp_odd;
    assign valid_o        = r_valid;
    assign res_o          = r_res;
    assign invalid_o      = r_invalid;
    assign err_o          = r_err;
    assign busy_o         = (r_state != StIdle);

endmodule

// File: tb/tb_sqrt_fp_controller.sv
// Directed bench for sqrt_fp_controller: normal, rounding, special, timeout, reset-abort and
// back-to-back sequences against hand-computed lampFP results.
module tb_sqrt_fp_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        doSqrt_i;
    logic [15:0] op_i;
    logic        core_start_o;
    logic [7:0]  core_s_o;
    logic        core_exp_odd_o;
    logic        core_valid_i;
    logic [15:0] core_res_i;
    logic        valid_o;
    logic [15:0] res_o;
    logic        invalid_o;
    logic        err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    sqrt_fp_controller #(.E_DW(8), .F_DW(7), .TIMEOUT(63)) dut (
        .clk            (clk),
        .rst            (rst),
        .doSqrt_i       (doSqrt_i),
        .op_i           (op_i),
        .core_start_o   (core_start_o),
        .core_s_o       (core_s_o),
        .core_exp_odd_o (core_exp_odd_o),
        .core_valid_i   (core_valid_i),
        .core_res_i     (core_res_i),
        .valid_o        (valid_o),
        .res_o          (res_o),
        .invalid_o      (invalid_o),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; doSqrt_i = 1'b0; op_i = 16'h0; core_valid_i = 1'b0; core_res_i = 16'h0;
        tick(); tick();
        checks++;
        if ({busy_o, valid_o, invalid_o, err_o, core_start_o, core_exp_odd_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000",
                     {busy_o, valid_o, invalid_o, err_o, core_start_o, core_exp_odd_o});
        end
        checks++;
        if (res_o !== 16'h0) begin
            errors++; $display("FAIL reset_res got %h exp 0000", res_o);
        end
        checks++;
        if (core_s_o !== 8'h0) begin
            errors++; $display("FAIL reset_core_s got %h exp 00", core_s_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic do_normal(input logic [15:0] op, input logic [15:0] cres,
                             input logic [7:0] exp_s, input logic exp_odd,
                             input logic [15:0] exp_res);
        doSqrt_i = 1'b1; op_i = op;
        tick();
        doSqrt_i = 1'b0;
        checks++;
        if (core_start_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++; $display("FAIL issue_start op=%h got start=%b busy=%b exp 1 1",
                               op, core_start_o, busy_o);
        end
        checks++;
        if (core_s_o !== exp_s || core_exp_odd_o !== exp_odd) begin
            errors++; $display("FAIL issue_operand op=%h got s=%h odd=%b exp s=%h odd=%b",
                               op, core_s_o, core_exp_odd_o, exp_s, exp_odd);
        end
        tick();
        checks++;
        if (core_start_o !== 1'b0) begin
            errors++; $display("FAIL wait_start op=%h got %b exp 0", op, core_start_o);
        end
        tick(); tick();
        core_valid_i = 1'b1; core_res_i = cres;
        tick();
        core_valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL post_early op=%h got valid=%b busy=%b exp 0 1",
                               op, valid_o, busy_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || res_o !== exp_res || invalid_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL result op=%h core=%h got v=%b res=%h inv=%b err=%b exp 1 %h 0 0",
                               op, cres, valid_o, res_o, invalid_o, err_o, exp_res);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL result_idle op=%h got busy=%b exp 0", op, busy_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || res_o !== 16'h0) begin
            errors++; $display("FAIL pulse op=%h got v=%b res=%h exp 0 0000", op, valid_o, res_o);
        end
    endtask

    task automatic test_normal();
        do_normal(16'h4080, 16'h4000, 8'h80, 1'b0, 16'h4000);
        do_normal(16'h4000, 16'h5A82, 8'h80, 1'b1, 16'h3FB5);
        do_normal(16'h4110, 16'h6000, 8'h90, 1'b1, 16'h4040);
    endtask

    task automatic test_rounding();
        do_normal(16'h3F80, 16'h7FFF, 8'h80, 1'b0, 16'h4000);
        do_normal(16'h3F80, 16'h3FFF, 8'h80, 1'b0, 16'h3F80);
        do_normal(16'h3F80, 16'h8000, 8'h80, 1'b0, 16'h4000);
    endtask

    task automatic test_special();
        logic [15:0] ops  [5] = '{16'hBF80, 16'h8000, 16'h7F80, 16'h7FA0, 16'h0001};
        logic [15:0] rexp [5] = '{16'h7FC0, 16'h8000, 16'h7F80, 16'h7FC0, 16'h0000};
        logic        iexp [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            doSqrt_i = 1'b1; op_i = ops[i];
            tick();
            doSqrt_i = 1'b0;
            checks++;
            if (valid_o !== 1'b1 || res_o !== rexp[i] || invalid_o !== iexp[i] || err_o !== 1'b0)
            begin
                errors++; $display("FAIL special op=%h got v=%b res=%h inv=%b err=%b exp 1 %h %b 0",
                                   ops[i], valid_o, res_o, invalid_o, err_o, rexp[i], iexp[i]);
            end
            checks++;
            if (core_start_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++; $display("FAIL special_idle op=%h got start=%b busy=%b exp 0 0",
                                   ops[i], core_start_o, busy_o);
            end
            tick();
            checks++;
            if (valid_o !== 1'b0 || invalid_o !== 1'b0) begin
                errors++; $display("FAIL special_pulse op=%h got v=%b inv=%b exp 0 0",
                                   ops[i], valid_o, invalid_o);
            end
        end
    endtask

    task automatic test_timeout();
        int n      = 0;
        int starts = 0;
        doSqrt_i = 1'b1; op_i = 16'h4080;
        tick();
        doSqrt_i = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            n = i;
            if (valid_o) break;
            if (core_start_o) starts++;
            doSqrt_i = (i % 10 == 5);
            op_i     = 16'h7F80;
        end
        doSqrt_i = 1'b0;
        checks++;
        if (n !== 64) begin
            errors++; $display("FAIL timeout_latency got %0d exp 64", n);
        end
        checks++;
        if (valid_o !== 1'b1 || res_o !== 16'h7FC0 || err_o !== 1'b1 || invalid_o !== 1'b0) begin
            errors++; $display("FAIL timeout_result got v=%b res=%h err=%b inv=%b exp 1 7fc0 1 0",
                               valid_o, res_o, err_o, invalid_o);
        end
        checks++;
        if (starts !== 0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL timeout_busy_ignore got starts=%0d busy=%b exp 0 0",
                               starts, busy_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse got v=%b err=%b exp 0 0", valid_o, err_o);
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        doSqrt_i = 1'b1; op_i = 16'h4080;
        tick();
        doSqrt_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b v=%b exp 0 0", busy_o, valid_o);
        end
        tick();
        core_valid_i = 1'b1; core_res_i = 16'h4000;
        tick();
        core_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (valid_o || busy_o) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL abort_late_valid got %0d active cycles exp 0", seen);
        end
        do_normal(16'h4080, 16'h4000, 8'h80, 1'b0, 16'h4000);
    endtask

    task automatic test_back_to_back();
        doSqrt_i = 1'b1; op_i = 16'h8000;
        tick();
        op_i = 16'h7F80;
        checks++;
        if (valid_o !== 1'b1 || res_o !== 16'h8000) begin
            errors++; $display("FAIL b2b_first got v=%b res=%h exp 1 8000", valid_o, res_o);
        end
        tick();
        op_i = 16'h4000;
        checks++;
        if (valid_o !== 1'b1 || res_o !== 16'h7F80) begin
            errors++; $display("FAIL b2b_second got v=%b res=%h exp 1 7f80", valid_o, res_o);
        end
        tick();
        doSqrt_i = 1'b0;
        checks++;
        if (core_start_o !== 1'b1 || core_exp_odd_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_issue got start=%b odd=%b v=%b exp 1 1 0",
                               core_start_o, core_exp_odd_o, valid_o);
        end
        tick();
        core_valid_i = 1'b1; core_res_i = 16'h5A82;
        tick();
        core_valid_i = 1'b0;
        doSqrt_i = 1'b1; op_i = 16'h7F80;
        tick();
        checks++;
        if (valid_o !== 1'b1 || res_o !== 16'h3FB5) begin
            errors++; $display("FAIL b2b_normal got v=%b res=%h exp 1 3fb5", valid_o, res_o);
        end
        tick();
        doSqrt_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || res_o !== 16'h7F80) begin
            errors++; $display("FAIL b2b_after_post got v=%b res=%h exp 1 7f80", valid_o, res_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_rounding();
        test_special();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1);
    end

endmodule

// File: doc/sqrt_fp_controller.md
SQRT_FP_CONTROLLER -- requirements
Module: sqrt_fp_controller

Interface
REQ-001 SHALL have parameter E_DW, default 8, exponent width of the 16-bit lampFP operand.
REQ-002 SHALL have parameter F_DW, default 7, stored fraction width; significand to the core is 1+F_DW bits.
REQ-003 SHALL have parameter TIMEOUT, default 63, maximum WAIT cycles before abort.
REQ-004 clk  in  1  single clock, all flops on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 doSqrt_i  in  1  start request, sampled only in IDLE.
REQ-007 op_i  in  16  operand {sign, exp[E_DW], frac[F_DW]}, sampled with doSqrt_i.
REQ-008 core_start_o  out  1  start pulse to the sqrt core.
REQ-009 core_s_o  out  8  significand {1, frac} to the core.
REQ-010 core_exp_odd_o  out  1  unbiased exponent odd; the core doubles the significand.
REQ-011 core_valid_i  in  1  core result valid.
REQ-012 core_res_i  in  16  core result, unsigned Q2.14.
REQ-013 valid_o  out  1  one-cycle result strobe.
REQ-014 res_o  out  16  packed lampFP result; 0x0000 when valid_o=0.
REQ-015 invalid_o  out  1  sqrt of negative non-zero, qualified by valid_o.
REQ-016 err_o  out  1  core timeout, qualified by valid_o.
REQ-017 busy_o  out  1  high whenever state != IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, POST.
REQ-019 IDLE + doSqrt_i: latch op_i; special operand -> registered result next cycle, stay IDLE; else -> ISSUE.
REQ-020 Special classes (E = exponent field): NaN (E=255, F!=0) -> 0x7FC0; +inf -> 0x7F80; +0 -> 0x0000; -0 -> 0x8000; denormal (E=0, F!=0) -> signed zero; negative non-zero incl. -inf -> 0x7FC0 with invalid_o=1.
REQ-021 ISSUE lasts exactly one cycle: core_start_o=1, core_s_o={1,F}, core_exp_odd_o=~E[0]; -> WAIT.
REQ-022 core_start_o SHALL be 0 in every other state; core_s_o and core_exp_odd_o hold the latched values.
REQ-023 Result exponent SHALL be (E+127)>>1 computed in 9 bits, i.e. floor(e/2)+127.
REQ-024 WAIT: counter from 0; core_valid_i=1 -> capture core_res_i, -> POST; counter reaching TIMEOUT -> res 0x7FC0, err_o=1, valid_o next cycle, -> IDLE.
REQ-025 POST normalise: bit15=1 -> shift right 1, exp+1; bit15=0 and bit14=0 -> shift left 1, exp-1; else unchanged.
REQ-026 POST round-nearest-even: frac=[13:7], guard=[6], sticky=|[5:0]; a carry out of frac SHALL set frac=0 and exp+1.
REQ-027 POST registers {0, exp, frac} into res_o; valid_o high the following cycle, FSM back in IDLE in that same cycle.
REQ-028 Normal-path latency: valid_o exactly 2 cycles after core_valid_i is sampled high.
REQ-029 Special-path latency: valid_o exactly 1 cycle after doSqrt_i is accepted; core_start_o never asserted.
REQ-030 doSqrt_i while busy_o=1 SHALL be ignored; core_valid_i outside WAIT SHALL be ignored.
REQ-031 valid_o, invalid_o and err_o SHALL be single-cycle pulses; invalid_o and err_o SHALL never both be high.
REQ-032 doSqrt_i accepted in the same cycle valid_o pulses (FSM in IDLE) SHALL be honoured.

Reset
REQ-033 rst SHALL force IDLE, counter 0, latched operand 0, and all outputs 0 on the next edge.
REQ-034 rst in any state SHALL abort; a late core_valid_i after reset SHALL produce no valid_o.

Verification
REQ-035 op 0x4080 (4.0), core_res 0x4000 -> core_exp_odd_o=0, core_s_o=0x80, res_o=0x4000, valid 2 cycles after core valid.
REQ-036 op 0x4000 (2.0), core_res 0x5A82 -> core_exp_odd_o=1, res_o=0x3FB5.
REQ-037 op 0x3F80, core_res 0x7FFF -> rounding carry, res_o=0x4000; core_res 0x3FFF -> left normalise then carry, res_o=0x3F80.
REQ-038 ops 0xBF80, 0x8000, 0x7F80, 0x7FA0, 0x0001 -> 0x7FC0 inv=1 / 0x8000 / 0x7F80 / 0x7FC0 / 0x0000, each 1 cycle, no core_start_o.
REQ-039 op 0x4080, core silent -> after 63 WAIT cycles res_o=0x7FC0, err_o=1; doSqrt_i pulses while busy are ignored.
REQ-040 rst asserted in WAIT, core_valid_i 2 cycles later -> busy_o=0, no valid_o, next request processed normally.
